// File: rtl/iir_out_serializer.sv
// Buffers IIR filter results in a small FIFO and shifts each one out as a start/data/stop serial frame.
// Define IIR_SER_PARITY_EN to insert an even-parity bit between the last data bit and the stop bit.
module iir_out_serializer #(
    parameter int unsigned W     = 5,
    parameter int unsigned DEPTH = 4,
    parameter int unsigned DIV   = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [W-1:0]             y,
    input  logic                     yval,
    output logic                     sdo,
    output logic                     sframe,
    output logic                     busy,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     overflow
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned LW = AW + 1;
    localparam int unsigned TW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int unsigned IW = (W > 1) ? $clog2(W) : 1;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
`ifdef IIR_SER_PARITY_EN
        PARITY,
`endif
        STOP
    } state_t;

    state_t          state, state_n;
    logic [TW-1:0]   tmr, tmr_n;
    logic [IW-1:0]   idx, idx_n;
    logic [W-1:0]    shift, shift_n;
`ifdef IIR_SER_PARITY_EN
    logic            par, par_n;
`endif
    logic            sdo_n, sframe_n, busy_n;
    logic [LW-1:0]   level_n;

    logic            yval_d;
    logic            cap, full, pop, acc, drop, bit_end;
    logic [W-1:0]    mem [DEPTH];
    logic [AW-1:0]   wr_ptr, rd_ptr;

    // A held-high yval yields a single sample; a slot freed by a same-edge pop is reusable
    assign cap     = yval && !yval_d;
    assign full    = (level == LW'(DEPTH));
    assign acc     = cap && (!full || pop);
    assign drop    = cap && full && !pop;
    assign bit_end = (tmr == TW'(DIV - 1));

    // Next-state, frame sequencing and next registered outputs
    always_comb begin
        state_n  = state;
        tmr_n    = tmr;
        idx_n    = idx;
        shift_n  = shift;
`ifdef IIR_SER_PARITY_EN
        par_n    = par;
`endif
        pop      = 1'b0;
        sdo_n    = 1'b1;
        sframe_n = 1'b0;

        case (state)
            IDLE: begin
                if (level != '0) begin
                    pop     = 1'b1;
                    shift_n = mem[rd_ptr];
`ifdef IIR_SER_PARITY_EN
                    par_n   = ^mem[rd_ptr];
`endif
                    tmr_n   = '0;
                    idx_n   = '0;
                    state_n = START;
                end
            end
            START: begin
                if (bit_end) begin
                    tmr_n   = '0;
                    state_n = DATA;
                end else begin
                    tmr_n = tmr + TW'(1);
                end
            end
            DATA: begin
                if (bit_end) begin
                    tmr_n   = '0;
                    shift_n = shift << 1;
                    if (idx == IW'(W - 1)) begin
`ifdef IIR_SER_PARITY_EN
                        state_n = PARITY;
`else
                        state_n = STOP;
`endif
                    end else begin
                        idx_n = idx + IW'(1);
                    end
                end else begin
                    tmr_n = tmr + TW'(1);
                end
            end
`ifdef IIR_SER_PARITY_EN
            PARITY: begin
                if (bit_end) begin
                    tmr_n   = '0;
                    state_n = STOP;
                end else begin
                    tmr_n = tmr + TW'(1);
                end
            end
`endif
            STOP: begin
                if (bit_end) begin
                    tmr_n   = '0;
                    state_n = IDLE;
                end else begin
                    tmr_n = tmr + TW'(1);
                end
            end
            default: state_n = IDLE;
        endcase

        // Line level follows the state being entered so sdo/sframe are registered
        case (state_n)
            START: begin
                sdo_n    = 1'b0;
                sframe_n = 1'b1;
            end
            DATA: begin
                sdo_n    = shift_n[W-1];
                sframe_n = 1'b1;
            end
`ifdef IIR_SER_PARITY_EN
            PARITY: begin
                sdo_n    = par_n;
                sframe_n = 1'b1;
            end
`endif
            STOP: begin
                sdo_n    = 1'b1;
                sframe_n = 1'b1;
            end
            default: begin
                sdo_n    = 1'b1;
                sframe_n = 1'b0;
            end
        endcase
    end

    always_comb begin
        level_n = level;
        case ({acc, pop})
            2'b10:   level_n = level + LW'(1);
            2'b01:   level_n = level - LW'(1);
            default: level_n = level;
        endcase
        busy_n = (level_n != '0) || (state_n != IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            tmr      <= '0;
            idx      <= '0;
            shift    <= '0;
`ifdef IIR_SER_PARITY_EN
            par      <= 1'b0;
`endif
            yval_d   <= 1'b0;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            level    <= '0;
            overflow <= 1'b0;
            sdo      <= 1'b1;
            sframe   <= 1'b0;
            busy     <= 1'b0;
        end else begin
            state    <= state_n;
            tmr      <= tmr_n;
            idx      <= idx_n;
            shift    <= shift_n;
`ifdef IIR_SER_PARITY_EN
            par      <= par_n;
`endif
            yval_d   <= yval;
            level    <= level_n;
            sdo      <= sdo_n;
            sframe   <= sframe_n;
            busy     <= busy_n;
            if (acc) wr_ptr <= wr_ptr + AW'(1);
            if (pop) rd_ptr <= rd_ptr + AW'(1);
            if (drop) overflow <= 1'b1;
        end
    end

    // Sample storage; contents are don't-care while the pointers are reset
    always_ff @(posedge clk) begin
        if (!rst && acc) mem[wr_ptr] <= y;
    end

endmodule

// File: tb/tb_iir_out_serializer.sv
// Bench for iir_out_serializer: directed frame table, corner sequences and a cycle-level reference model.
module tb_iir_out_serializer;

    localparam int W     = 5;
    localparam int DEPTH = 4;
    localparam int DIV   = 4;
`ifdef IIR_SER_PARITY_EN
    localparam int PAR   = 1;
`else
    localparam int PAR   = 0;
`endif
    localparam int NB    = W + 2 + PAR;
    localparam int FRAME = NB * DIV;
    localparam int LW    = $clog2(DEPTH) + 1;

    logic          clk;
    logic          rst;
    logic [W-1:0]  y;
    logic          yval;
    logic          sdo;
    logic          sframe;
    logic          busy;
    logic [LW-1:0] level;
    logic          overflow;

    iir_out_serializer #(.W(W), .DEPTH(DEPTH), .DIV(DIV)) dut (
        .clk      (clk),
        .rst      (rst),
        .y        (y),
        .yval     (yval),
        .sdo      (sdo),
        .sframe   (sframe),
        .busy     (busy),
        .level    (level),
        .overflow (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endfunction

    function automatic void timeout(input string name);
        tests++;
        fails++;
        $display("FAIL %s: wait expired at %0t", name, $time);
    endfunction

    // Reference model: sample queue plus the cycle at which the current frame began
    logic [W-1:0]  q[$];
    int            cyc     = 0;
    int            next_ok = 0;
    int            fr_start = 0;
    bit            have    = 0;
    bit            yd      = 0;
    bit            ovf_m   = 0;
    bit            started = 0;
    logic [W-1:0]  cur     = '0;
    logic [LW+3:0] exp_vec = '0;

    initial begin
        bit   capm, popm, fullm, inf;
        int   k, b;
        logic e_sdo;
        forever begin
            @(posedge clk);
            if (rst) begin
                q.delete();
                ovf_m   = 0;
                yd      = 0;
                have    = 0;
                next_ok = cyc;
                started = 1;
            end else begin
                capm  = yval && !yd;
                yd    = yval;
                fullm = (q.size() == DEPTH);
                popm  = (cyc >= next_ok) && (q.size() > 0);
                if (popm) begin
                    cur      = q.pop_front();
                    fr_start = cyc;
                    next_ok  = cyc + FRAME + 1;
                    have     = 1;
                end
                if (capm) begin
                    if (!fullm || popm) q.push_back(y);
                    else ovf_m = 1;
                end
            end
            k   = cyc - fr_start;
            inf = have && (k >= 0) && (k < FRAME);
            e_sdo = 1'b1;
            if (inf) begin
                b = k / DIV;
                if (b == 0)                       e_sdo = 1'b0;
                else if (b <= W)                  e_sdo = cur[W-b];
                else if (PAR == 1 && b == W + 1)  e_sdo = ^cur;
                else                              e_sdo = 1'b1;
            end
            exp_vec = {e_sdo, inf, inf || (q.size() > 0), LW'(q.size()), ovf_m};
            cyc++;
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            if (started)
                check("cycle", 32'({sdo, sframe, busy, level, overflow}), 32'(exp_vec));
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic [W-1:0] y;
        logic [W+1:0] seq;   // start, data MSB first, stop
        logic         par;
    } vec_t;

    function automatic logic exp_bit(input vec_t v, input int b);
`ifdef IIR_SER_PARITY_EN
        if (b == W + 1) return v.par;
        if (b == W + 2) return v.seq[0];
`endif
        return v.seq[W+1-b];
    endfunction

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic do_reset(input int n);
        rst = 1'b1;
        repeat (n) tick();
        rst = 1'b0;
    endtask

    task automatic pulse(input logic [W-1:0] v);
        y    = v;
        yval = 1'b1;
        tick();
        yval = 1'b0;
    endtask

    // Waits for a frame, checks its length and framing bits, returns the data field
    task automatic get_frame(input string name, output logic [W-1:0] d, output bit ok);
        logic [NB-1:0] bits;
        int n;
        int hi;
        n    = 0;
        hi   = 0;
        ok   = 0;
        d    = '0;
        bits = '0;
        while (sframe !== 1'b1 && n < 200) begin
            tick();
            n++;
        end
        if (sframe !== 1'b1) begin
            timeout(name);
            return;
        end
        for (int c = 0; c < FRAME; c++) begin
            if (c % DIV == DIV / 2) bits = {bits[NB-2:0], sdo};
            if (sframe === 1'b1) hi++;
            tick();
        end
        check({name, "_len"}, 32'(hi), 32'(FRAME));
        check({name, "_end"}, 32'(sframe), 32'(0));
        check({name, "_start"}, 32'(bits[NB-1]), 32'(0));
        check({name, "_stop"}, 32'(bits[0]), 32'(1));
        d = bits[NB-2 -: W];
`ifdef IIR_SER_PARITY_EN
        check({name, "_par"}, 32'(bits[1]), 32'(^d));
`endif
        ok = 1;
    endtask

    vec_t tbl[6];

    initial begin
        logic [W-1:0] d;
        bit           ok;
        int           peak, frames;
        logic         prev_sf;
        int           n;

        tbl[0] = '{5'b10110, 7'b0101101, 1'b1};
        tbl[1] = '{5'b00000, 7'b0000001, 1'b0};
        tbl[2] = '{5'b11111, 7'b0111111, 1'b1};
        tbl[3] = '{5'b00011, 7'b0000111, 1'b0};
        tbl[4] = '{5'b10001, 7'b0100011, 1'b0};
        tbl[5] = '{5'b01011, 7'b0010111, 1'b1};

        rst  = 1'b1;
        yval = 1'b0;
        y    = '0;
        repeat (2) tick();
        rst = 1'b0;
        check("rst_sdo", 32'(sdo), 32'(1));
        check("rst_sframe", 32'(sframe), 32'(0));
        check("rst_busy", 32'(busy), 32'(0));
        check("rst_level", 32'(level), 32'(0));
        check("rst_ovf", 32'(overflow), 32'(0));

        // Single isolated samples: exact line waveform, cycle by cycle
        for (int i = 0; i < 6; i++) begin
            pulse(tbl[i].y);
            check("tbl_level", 32'(level), 32'(1));
            check("tbl_pre", 32'(sframe), 32'(0));
            tick();
            for (int c = 0; c < FRAME; c++) begin
                check("tbl_bit", 32'({sframe, sdo}), 32'({1'b1, exp_bit(tbl[i], c / DIV)}));
                tick();
            end
            check("tbl_idle", 32'({sframe, sdo, busy}), 32'(3'b010));
        end

        // yval held high with y changing: one sample only
        peak    = 0;
        frames  = 0;
        prev_sf = sframe;
        yval    = 1'b1;
        for (int i = 0; i < 50 + FRAME + 5; i++) begin
            if (i == 50) yval = 1'b0;
            y = W'($urandom);
            tick();
            if (int'(level) > peak) peak = int'(level);
            if (sframe && !prev_sf) frames++;
            prev_sf = sframe;
        end
        check("held_frames", 32'(frames), 32'(1));
        check("held_peak", 32'(peak), 32'(1));

        // Six edges two cycles apart: 1..5 sent in order, 6 dropped
        do_reset(1);
        fork
            begin
                for (int v = 1; v <= 6; v++) begin
                    y    = W'(v);
                    yval = 1'b1;
                    tick();
                    yval = 1'b0;
                    tick();
                end
                check("ovf_set", 32'(overflow), 32'(1));
            end
            begin
                logic [W-1:0] fd;
                bit           fok;
                for (int v = 1; v <= 5; v++) begin
                    get_frame("ovf_frame", fd, fok);
                    if (fok) check("ovf_order", 32'(fd), 32'(v));
                end
            end
        join
        tick();
        check("ovf_sticky", 32'(overflow), 32'(1));
        check("ovf_drained", 32'({busy, level}), 32'(0));

        // Capture on the very edge where a full FIFO is popped
        do_reset(1);
        check("full_ovf_clr", 32'(overflow), 32'(0));
        fork
            begin
                int m;
                for (int v = 11; v <= 15; v++) begin
                    y    = W'(v);
                    yval = 1'b1;
                    tick();
                    yval = 1'b0;
                    tick();
                end
                m = 0;
                while (!(sframe === 1'b0 && level == LW'(DEPTH)) && m < 100) begin
                    tick();
                    m++;
                end
                if (m >= 100) begin
                    timeout("full_wait");
                end else begin
                    y    = W'(16);
                    yval = 1'b1;
                    tick();
                    yval = 1'b0;
                    check("full_pop_level", 32'(level), 32'(DEPTH));
                    check("full_pop_ovf", 32'(overflow), 32'(0));
                end
            end
            begin
                logic [W-1:0] fd;
                bit           fok;
                for (int v = 11; v <= 16; v++) begin
                    get_frame("full_frame", fd, fok);
                    if (fok) check("full_order", 32'(fd), 32'(v));
                end
            end
        join
        check("full_no_ovf", 32'(overflow), 32'(0));

        // Reset during data bit 2 abandons the frame and flushes the FIFO
        do_reset(1);
        pulse(5'b10101);
        tick();
        pulse(5'b01110);
        repeat (12) tick();
        check("mid_sframe", 32'(sframe), 32'(1));
        check("mid_sdo", 32'(sdo), 32'(1));
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("mid_rst_line", 32'({sdo, sframe}), 32'(2'b10));
        check("mid_rst_level", 32'(level), 32'(0));
        repeat (3) tick();
        check("mid_no_resume", 32'({sframe, busy}), 32'(0));
        pulse(5'b00011);
        get_frame("post_rst", d, ok);
        if (ok) check("post_rst_data", 32'(d), 32'(3));

        // Random traffic against the model: dense, then a reset, then near the service rate
        do_reset(1);
        for (int i = 0; i < 700; i++) begin
            y = W'($urandom);
            if (i < 300) yval = ($urandom_range(0, 2) == 0);
            else if ($urandom_range(0, 11) == 0) yval = ~yval;
            rst = (i == 300);
            tick();
        end
        rst  = 1'b0;
        yval = 1'b0;
        n = 0;
        while (busy !== 1'b0 && n < 400) begin
            tick();
            n++;
        end
        if (busy !== 1'b0) timeout("drain");
        else check("drain_level", 32'(level), 32'(0));
        tick();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
